// File: rtl/core_pkg.sv
// core_pkg: forwarding select encodings, load-bit index and forward-priority helper shared by the hazard logic.
package core_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam int RS_LOAD_BIT = 0;
  function automatic logic [1:0] fwd_sel(input logic hit_m, input logic hit_w);
    return hit_m ? FWD_MEM : hit_w ? FWD_WB : FWD_RF;
  endfunction
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register busy bits, in-flight op counter and sticky error for multi-cycle ops.
module hazard_scoreboard
  import core_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_OUT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_issue,
  input  logic [AW-1:0]   i_issue_rd,
  input  logic            i_done,
  input  logic [AW-1:0]   i_done_rd,
  output logic [NREG-1:0] o_busy,
  output logic            o_full,
  output logic            o_error
);
  localparam logic [AW-1:0] MAX_C = AW'(MAX_OUT);
  logic [NREG-1:0] r_busy;
  logic [AW-1:0]   r_out;
  logic            r_err;
  logic            w_done_ok, w_empty, w_inc, w_dec;
  logic [NREG-1:0] w_set, w_clr;
  assign w_done_ok = i_done && r_busy[i_done_rd];
  assign w_empty   = r_out == '0;
  assign o_full    = r_out == MAX_C;
  // a simultaneous issue and valid done cancel out in the counter
  assign w_inc     = i_issue && !w_done_ok;
  assign w_dec     = w_done_ok && !i_issue;
  // set is applied after clear so a same-register issue keeps the bit busy
  assign w_set     = (i_issue && i_issue_rd != '0) ? NREG'(1) << i_issue_rd : '0;
  assign w_clr     = w_done_ok ? NREG'(1) << i_done_rd : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
      r_out  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (r_busy & ~w_clr) | w_set;
      r_out  <= (w_inc && !o_full) ? r_out + 1'b1 : (w_dec && !w_empty) ? r_out - 1'b1 : r_out;
      r_err  <= r_err | (i_done && !r_busy[i_done_rd]) | (w_inc && o_full) | (w_dec && w_empty);
    end
  end
  assign o_busy  = r_busy;
  assign o_error = r_err;
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: EX forwarding, load-use/scoreboard/capacity stalls, branch flush and stall-cycle counter.
module hazard_scoreboard_unit
  import core_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int AW      = 5,
  parameter int MAX_OUT = 4,
  parameter int CNTW    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   Rs1E,
  input  logic [AW-1:0]   Rs2E,
  input  logic [AW-1:0]   RdE,
  input  logic [AW-1:0]   RdM,
  input  logic [AW-1:0]   RdW,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  input  logic [AW-1:0]   RdD,
  input  logic [1:0]      ResultSrcE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic [1:0]      PCSrcE,
  input  logic            McOpD,
  input  logic            McIssueE,
  input  logic            McDone,
  input  logic [AW-1:0]   McRd,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushD,
  output logic            FlushE,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [CNTW-1:0] StallCount,
  output logic            ScbError
);
  logic [NREG-1:0] w_busy;
  logic            w_full, w_lw, w_raw, w_waw, w_cap, w_stall, w_unused;
  logic [CNTW-1:0] r_cnt;
  hazard_scoreboard #(.NREG(NREG), .AW(AW), .MAX_OUT(MAX_OUT)) u_scb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_issue    (McIssueE),
    .i_issue_rd (RdE),
    .i_done     (McDone),
    .i_done_rd  (McRd),
    .o_busy     (w_busy),
    .o_full     (w_full),
    .o_error    (ScbError)
  );
  // a busy register's latest value comes from the op-result path, never a bypass
  assign ForwardAE = fwd_sel(RegWriteM && RdM != '0 && RdM == Rs1E && !w_busy[Rs1E],
                             RegWriteW && RdW != '0 && RdW == Rs1E && !w_busy[Rs1E]);
  assign ForwardBE = fwd_sel(RegWriteM && RdM != '0 && RdM == Rs2E && !w_busy[Rs2E],
                             RegWriteW && RdW != '0 && RdW == Rs2E && !w_busy[Rs2E]);
  assign w_lw      = ResultSrcE[RS_LOAD_BIT] && ((A1 != '0 && A1 == RdE) || (A2 != '0 && A2 == RdE));
  assign w_raw     = (w_busy[A1] && A1 != '0) || (w_busy[A2] && A2 != '0);
  assign w_waw     = w_busy[RdD] && RdD != '0;
  assign w_cap     = McOpD && w_full;
  assign w_stall   = w_lw || w_raw || w_waw || w_cap;
  assign w_unused  = ResultSrcE[1];
  assign StallF    = w_stall;
  assign StallD    = w_stall;
  assign FlushE    = w_stall;
  assign FlushD    = PCSrcE != 2'b00;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= (w_stall && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
  end
  assign StallCount = r_cnt;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// tb_hazard_scoreboard_unit: directed plus randomized stimulus, expected outputs queued from a reference model.
module tb_hazard_scoreboard_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] Rs1E, Rs2E, RdE, RdM, RdW, A1, A2, RdD, McRd;
  logic [1:0] ResultSrcE, PCSrcE, ForwardAE, ForwardBE;
  logic RegWriteM, RegWriteW, McOpD, McIssueE, McDone;
  logic StallF, StallD, FlushD, FlushE, ScbError;
  logic [15:0] StallCount;
  always #5 clk = ~clk;
  hazard_scoreboard_unit dut (
    .clk(clk), .rst_n(rst_n), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RdM(RdM), .RdW(RdW),
    .A1(A1), .A2(A2), .RdD(RdD), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM),
    .RegWriteW(RegWriteW), .PCSrcE(PCSrcE), .McOpD(McOpD), .McIssueE(McIssueE),
    .McDone(McDone), .McRd(McRd), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallCount(StallCount), .ScbError(ScbError)
  );
  typedef struct {
    logic [4:0] rs1e, rs2e, rde, rdm, rdw, a1, a2, rdd, mcrd;
    logic [1:0] rsrc, pcsrc;
    logic rwm, rww, mcop, iss, done;
  } stim_t;
  typedef struct {
    logic sf, sd, fd, fe, err;
    logic [1:0] fa, fb;
    logic [15:0] cnt;
  } exp_t;
  exp_t q[$];
  exp_t me;
  stim_t st;
  bit mbusy[32];
  int mout, mcnt, n_tests, n_fail;
  bit merr;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask
  function automatic stim_t idle();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction
  function automatic logic [1:0] mfwd(input logic [4:0] rs);
    if (st.rwm && st.rdm != 0 && st.rdm == rs && !mbusy[rs]) return 2'b10;
    if (st.rww && st.rdw != 0 && st.rdw == rs && !mbusy[rs]) return 2'b01;
    return 2'b00;
  endfunction
  task automatic mclear();
    foreach (mbusy[i]) mbusy[i] = 0;
    mout = 0;
    mcnt = 0;
    merr = 0;
  endtask
  task automatic go();
    exp_t e;
    bit stall, ok;
    @(posedge clk); #1;
    Rs1E = st.rs1e; Rs2E = st.rs2e; RdE = st.rde; RdM = st.rdm; RdW = st.rdw;
    A1 = st.a1; A2 = st.a2; RdD = st.rdd; McRd = st.mcrd; ResultSrcE = st.rsrc;
    PCSrcE = st.pcsrc; RegWriteM = st.rwm; RegWriteW = st.rww; McOpD = st.mcop;
    McIssueE = st.iss; McDone = st.done;
    stall = (st.rsrc[0] && ((st.a1 != 0 && st.a1 == st.rde) || (st.a2 != 0 && st.a2 == st.rde)))
         || (st.a1 != 0 && mbusy[st.a1]) || (st.a2 != 0 && mbusy[st.a2])
         || (st.rdd != 0 && mbusy[st.rdd]) || (st.mcop && mout == 4);
    e.sf = stall; e.sd = stall; e.fe = stall; e.fd = st.pcsrc != 0;
    e.fa = mfwd(st.rs1e); e.fb = mfwd(st.rs2e); e.cnt = 16'(mcnt); e.err = merr;
    q.push_back(e);
    ok = st.done && mbusy[st.mcrd];
    if (st.done && !ok) merr = 1;
    if (ok) mbusy[st.mcrd] = 0;
    if (st.iss && st.rde != 0) mbusy[st.rde] = 1;
    if (st.iss && !ok) begin if (mout == 4) merr = 1; else mout++; end
    if (ok && !st.iss) begin if (mout == 0) merr = 1; else mout--; end
    if (stall && mcnt < 65535) mcnt++;
    st = idle();
  endtask
  task automatic do_reset();
    q.delete();
    rst_n = 1'b0;
    mclear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("stallF", StallF, me.sf);
      chk("stallD", StallD, me.sd);
      chk("flushD", FlushD, me.fd);
      chk("flushE", FlushE, me.fe);
      chk("fwdA", ForwardAE, me.fa);
      chk("fwdB", ForwardBE, me.fb);
      chk("stall_count", StallCount, me.cnt);
      chk("scb_error", ScbError, me.err);
    end
  end
  initial begin
    int bl[$], fr[$];
    st = idle();
    mclear();
    {Rs1E, Rs2E, RdE, RdM, RdW, A1, A2, RdD, McRd} = '0;
    {ResultSrcE, PCSrcE, RegWriteM, RegWriteW, McOpD, McIssueE, McDone} = '0;
    do_reset();
    #1;
    chk("reset_stall", StallD, 0);
    chk("reset_count", StallCount, 0);
    chk("reset_err", ScbError, 0);
    // forwarding priority and zero-register qualification
    st.rs1e = 5; st.rdm = 5; st.rwm = 1; st.rs2e = 6; st.rdw = 6; st.rww = 1; go(); #1;
    chk("fwd_mem_A", ForwardAE, 2'b10); chk("fwd_wb_B", ForwardBE, 2'b01);
    st.rs1e = 5; st.rdm = 0; st.rwm = 1; st.rs2e = 6; st.rdw = 6; st.rww = 1; go(); #1;
    chk("fwd_rd0_A", ForwardAE, 2'b00);
    st.rs1e = 5; st.rdm = 5; st.rwm = 0; st.rdw = 5; st.rww = 1; go(); #1;
    chk("fwd_wb_noM", ForwardAE, 2'b01);
    // load-use for one cycle
    st.rsrc = 2'b01; st.rde = 7; st.a2 = 7; go(); #1;
    chk("lw_stall", StallD, 1); chk("lw_cnt0", StallCount, 0);
    go(); #1;
    chk("lw_release", StallD, 0); chk("lw_cnt1", StallCount, 1);
    // scoreboard RAW held until the cycle after done
    st.iss = 1; st.rde = 9; go();
    for (int k = 1; k <= 7; k++) begin
      st.a1 = 9;
      if (k == 6) begin st.done = 1; st.mcrd = 9; end
      go(); #1;
      chk("raw_hold", StallD, k <= 6);
    end
    // same-register issue and done keeps busy, counter unchanged
    st.iss = 1; st.rde = 3; go();
    st.iss = 1; st.rde = 3; st.done = 1; st.mcrd = 3; go();
    st.a1 = 3; go(); #1; chk("same_reg_busy", StallD, 1);
    st.iss = 1; st.rde = 1; go();
    st.iss = 1; st.rde = 2; go();
    st.mcop = 1; go(); #1; chk("cap_three", StallD, 0);
    st.iss = 1; st.rde = 4; go();
    st.mcop = 1; go(); #1; chk("cap_full", StallD, 1);
    st.mcop = 1; st.done = 1; st.mcrd = 1; go(); #1; chk("cap_done_cycle", StallD, 1);
    st.mcop = 1; go(); #1; chk("cap_drop", StallD, 0);
    st.iss = 1; st.rde = 5; go();
    st.iss = 1; st.rde = 6; go(); #1; chk("ovf_pre", ScbError, 0);
    go(); #1; chk("ovf_err", ScbError, 1);
    // branch with load-use, then asynchronous reset with ops in flight
    do_reset();
    st.rsrc = 2'b01; st.rde = 7; st.a1 = 7; st.pcsrc = 2'b01; go(); #1;
    chk("br_flushD", FlushD, 1); chk("br_flushE", FlushE, 1); chk("br_stallF", StallF, 1);
    for (int r = 2; r <= 4; r++) begin st.iss = 1; st.rde = 5'(r); go(); end
    st.a1 = 2; go(); #1;
    chk("pre_rst_stall", StallD, 1); chk("pre_rst_cnt", StallCount, 1);
    #1;
    q.delete();
    rst_n = 1'b0;
    #1;
    chk("async_stall", StallD, 0); chk("async_flushE", FlushE, 0);
    chk("async_cnt", StallCount, 0);
    mclear();
    @(negedge clk);
    rst_n = 1'b1;
    st.done = 1; st.mcrd = 2; go(); #1; chk("post_rst_err0", ScbError, 0);
    go(); #1; chk("post_rst_done_err", ScbError, 1);
    // randomized legal traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      bl.delete(); fr.delete();
      for (int r = 1; r < 8; r++) if (mbusy[r]) bl.push_back(r); else fr.push_back(r);
      st.rs1e = 5'($urandom_range(0, 7)); st.rs2e = 5'($urandom_range(0, 7));
      st.rde = 5'($urandom_range(0, 7));  st.rdm = 5'($urandom_range(0, 7));
      st.rdw = 5'($urandom_range(0, 7));  st.a1 = 5'($urandom_range(0, 7));
      st.a2 = 5'($urandom_range(0, 7));   st.rdd = 5'($urandom_range(0, 7));
      st.rsrc = 2'($urandom_range(0, 3));
      st.pcsrc = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      st.rwm = 1'($urandom_range(0, 1)); st.rww = 1'($urandom_range(0, 1));
      st.mcop = 1'($urandom_range(0, 1));
      if (mout < 4 && fr.size() > 0 && $urandom_range(0, 2) == 0) begin
        st.iss = 1; st.rde = 5'(fr[$urandom_range(0, fr.size() - 1)]);
      end
      if (bl.size() > 0 && $urandom_range(0, 3) == 0) begin
        st.done = 1; st.mcrd = 5'(bl[$urandom_range(0, bl.size() - 1)]);
      end
      go();
    end
    @(negedge clk); #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
